// File: rtl/jit_inst_sequencer_pkg.sv
// Shared definitions for the bytecode-to-ARM emission sequencer: default widths,
// FSM state encoding, patch selector codes and the continuation-flag position.
package jit_inst_sequencer_pkg;

    localparam int DEF_OPC_W     = 8;
    localparam int DEF_ADR_W     = 7;
    localparam int DEF_INSN_W    = 32;
    localparam int DEF_OPR_W     = 16;
    localparam int DEF_MAX_WORDS = 16;

    // rom_idx = {chain_flag, key}; the flag sits just above the opcode bits.
    localparam int CHAIN_FLAG_BIT = DEF_OPC_W;

    localparam int IMM8_W  = 8;
    localparam int IMM12_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FETCH  = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PATCH_NONE  = 2'd0,
        PATCH_IMM8  = 2'd1,
        PATCH_IMM12 = 2'd2,
        PATCH_RSVD  = 2'd3
    } patch_t;

endpackage

// File: rtl/jit_inst_sequencer_patch_unit.sv
// Combinational immediate patcher: splices the low operand bits into an ARM
// template word according to the template's patch selector.
module jit_inst_sequencer_patch_unit
    import jit_inst_sequencer_pkg::*;
#(
    parameter int INSN_W = DEF_INSN_W,
    parameter int OPR_W  = DEF_OPR_W
) (
    input  logic [INSN_W-1:0] insn,
    input  logic [1:0]        patch_sel,
    input  logic [OPR_W-1:0]  operand,
    output logic [INSN_W-1:0] patched
);

    logic sel_imm8;
    logic sel_imm12;
    logic unused_operand_hi;

    assign sel_imm8  = (patch_sel == PATCH_IMM8);
    assign sel_imm12 = (patch_sel == PATCH_IMM12);

    // Only the low 12 operand bits can ever reach an immediate field.
    assign unused_operand_hi = ^operand[OPR_W-1:IMM12_W];

    genvar gi;
    generate
        for (gi = 0; gi < INSN_W; gi++) begin : g_bit
            if (gi < IMM8_W) begin : g_imm8
                assign patched[gi] = (sel_imm8 | sel_imm12) ? operand[gi] : insn[gi];
            end else if (gi < IMM12_W) begin : g_imm12
                assign patched[gi] = sel_imm12 ? operand[gi] : insn[gi];
            end else begin : g_pass
                assign patched[gi] = insn[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/jit_inst_sequencer.sv
// Bytecode-to-ARM emission sequencer: looks up a template start address per JVM
// bytecode, walks the template ROM, patches immediates and streams ARM words.
module jit_inst_sequencer
    import jit_inst_sequencer_pkg::*;
#(
    parameter int OPC_W     = DEF_OPC_W,
    parameter int ADR_W     = DEF_ADR_W,
    parameter int INSN_W    = DEF_INSN_W,
    parameter int OPR_W     = DEF_OPR_W,
    parameter int MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bc_valid,
    output logic              bc_ready,
    input  logic [OPC_W-1:0]  bc_opcode,
    input  logic [OPR_W-1:0]  bc_operand,
    output logic [OPC_W:0]    rom_idx,
    input  logic [ADR_W-1:0]  rom_adr,
    output logic [ADR_W-1:0]  tpl_adr,
    input  logic [INSN_W-1:0] tpl_insn,
    input  logic [1:0]        tpl_patch,
    input  logic              tpl_last,
    input  logic              tpl_chain_en,
    input  logic [OPC_W-1:0]  tpl_chain,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INSN_W-1:0] out_insn,
    output logic              out_last,
    output logic              err_unsup,
    output logic              err_ovr
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    state_t              state_reg,    state_next;
    logic [OPC_W:0]      rom_idx_reg,  rom_idx_next;
    logic [ADR_W-1:0]    tpl_adr_reg,  tpl_adr_next;
    logic [OPR_W-1:0]    operand_reg,  operand_next;
    logic [CNT_W-1:0]    cnt_reg,      cnt_next;
    logic [INSN_W-1:0]   insn_reg,     insn_next;
    logic                last_reg,     last_next;
    logic                chain_en_reg, chain_en_next;
    logic [OPC_W-1:0]    chain_reg,    chain_next;
    logic                err_ovr_reg,  err_ovr_next;
    logic                unsup_hit;
    logic [CNT_W-1:0]    cnt_inc;
    logic [INSN_W-1:0]   patched_insn;

    jit_inst_sequencer_patch_unit #(
        .INSN_W (INSN_W),
        .OPR_W  (OPR_W)
    ) u_patch (
        .insn      (tpl_insn),
        .patch_sel (tpl_patch),
        .operand   (operand_reg),
        .patched   (patched_insn)
    );

    assign cnt_inc = cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            rom_idx_reg  <= '0;
            tpl_adr_reg  <= '0;
            operand_reg  <= '0;
            cnt_reg      <= '0;
            insn_reg     <= '0;
            last_reg     <= 1'b0;
            chain_en_reg <= 1'b0;
            chain_reg    <= '0;
            err_ovr_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rom_idx_reg  <= rom_idx_next;
            tpl_adr_reg  <= tpl_adr_next;
            operand_reg  <= operand_next;
            cnt_reg      <= cnt_next;
            insn_reg     <= insn_next;
            last_reg     <= last_next;
            chain_en_reg <= chain_en_next;
            chain_reg    <= chain_next;
            err_ovr_reg  <= err_ovr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rom_idx_next  = rom_idx_reg;
        tpl_adr_next  = tpl_adr_reg;
        operand_next  = operand_reg;
        cnt_next      = cnt_reg;
        insn_next     = insn_reg;
        last_next     = last_reg;
        chain_en_next = chain_en_reg;
        chain_next    = chain_reg;
        err_ovr_next  = 1'b0;
        unsup_hit     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bc_valid) begin
                    operand_next = bc_operand;
                    rom_idx_next = {1'b0, bc_opcode};
                    cnt_next     = '0;
                    state_next   = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (rom_adr == '0) begin
                    unsup_hit  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    tpl_adr_next = rom_adr;
                    state_next   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Template word is valid while tpl_adr holds its new address.
                insn_next     = patched_insn;
                last_next     = tpl_last;
                chain_en_next = tpl_chain_en;
                chain_next    = tpl_chain;
                state_next    = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    cnt_next = cnt_inc;
                    if (last_reg) begin
                        state_next = ST_IDLE;
                    end else if (cnt_inc == CNT_W'(MAX_WORDS)) begin
                        err_ovr_next = 1'b1;
                        state_next   = ST_IDLE;
                    end else if (chain_en_reg) begin
                        rom_idx_next = {1'b1, chain_reg};
                        state_next   = ST_LOOKUP;
                    end else if (tpl_adr_reg == '1) begin
                        err_ovr_next = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        tpl_adr_next = tpl_adr_reg + 1'b1;
                        state_next   = ST_FETCH;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake and error outputs are forced low while reset is held.
    assign bc_ready  = (state_reg == ST_IDLE) && !rst;
    assign out_valid = (state_reg == ST_EMIT) && !rst;
    assign out_last  = last_reg && out_valid;
    assign out_insn  = insn_reg;
    assign rom_idx   = rom_idx_reg;
    assign tpl_adr   = tpl_adr_reg;
    assign err_unsup = unsup_hit && !rst;
    assign err_ovr   = err_ovr_reg && !rst;

endmodule
